// File: rtl/pipeline_sequencer.sv
// Purpose : stall/flush sequencer for a 5-stage in-order pipeline (IF/ID/EX/MEM/WB).
// Latency : control outputs are combinational from current state and inputs (0 cycles).
// Backpressure: data-memory wait freezes PC, IF/ID, ID/EX and EX/MEM and bubbles MEM/WB until dhit.
//
// Ports
//   CLK, nRST                      clock (rising edge), asynchronous active-low reset
//   ihit, dmem_req, dhit           instruction-fetch hit, MEM load/store pending, data access done
//   take_branch, jump, halt_wb     ID redirect events, HALT reached WB
//   id_rs, id_rt                   source registers of the instruction in ID
//   idex_rd/regwrite/memread       destination and control of the instruction in EX
//   xmem_rd/regwrite/memread       destination and control of the instruction in MEM
//   pc_en                          PC may load its next value
//   stall_<latch>                  latch holds its contents
//   flush_<latch>                  latch loads a bubble
//   halted                         sticky halt flag
//   seq_state                      RUN=0, DWAIT=1, BUBBLE=2, HALTED=3
//
// Build option: define PIPELINE_SEQUENCER_FORWARD_EN when the datapath has full
// EX/MEM forwarding; then only a load-use dependency on the EX instruction stalls
// (one bubble). Without it, an EX producer costs two bubbles and a MEM-only
// producer costs one.

module pipeline_sequencer (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dmem_req,
    input  logic       dhit,
    input  logic       take_branch,
    input  logic       jump,
    input  logic       halt_wb,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] idex_rd,
    input  logic [4:0] xmem_rd,
    input  logic       idex_regwrite,
    input  logic       idex_memread,
    input  logic       xmem_regwrite,
    input  logic       xmem_memread,
    output logic       pc_en,
    output logic       stall_ifid,
    output logic       stall_idex,
    output logic       stall_xmem,
    output logic       stall_wb,
    output logic       flush_ifid,
    output logic       flush_idex,
    output logic       flush_xmem,
    output logic       flush_wb,
    output logic       halted,
    output logic [1:0] seq_state
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DWAIT  = 2'd1,
        S_BUBBLE = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t     state;
    // Remaining bubble cycles after the current one. The cycle that detects a
    // RAW hazard already issues the first bubble, so the counter is loaded with
    // (required bubbles - 1) and is only ever nonzero in BUBBLE or a DWAIT
    // entered from BUBBLE.
    logic [1:0] bub_cnt;

    // ------------------------------------------------------------------
    // Hazard detection. Register 0 is hardwired, so a producer writing r0
    // never creates a dependency.
    // ------------------------------------------------------------------
    logic       ex_match;
    logic       mem_match;
    logic       raw_hazard;
    logic [1:0] raw_load;
    logic       dwait_req;

    assign ex_match  = idex_regwrite && (idex_rd != 5'd0) &&
                       ((id_rs == idex_rd) || (id_rt == idex_rd));
    assign mem_match = xmem_regwrite && (xmem_rd != 5'd0) &&
                       ((id_rs == xmem_rd) || (id_rt == xmem_rd));

`ifdef PIPELINE_SEQUENCER_FORWARD_EN
    // Forwarding covers every ALU result; only a load in EX cannot forward
    // into the following instruction's EX in time.
    assign raw_hazard = ex_match && idex_memread;
    assign raw_load   = 2'd1;

    // MEM-stage producer information is not needed when forwarding exists.
    logic unused_mem_info;
    assign unused_mem_info = &{1'b0, mem_match, xmem_memread};
`else
    // No forwarding: wait for the producer to reach WB (register file is
    // write-before-read). An EX producer is two stages away, a MEM producer one.
    assign raw_hazard = ex_match || mem_match;
    assign raw_load   = ex_match ? 2'd2 : 2'd1;

    // Load/non-load distinction is irrelevant without forwarding.
    logic unused_memread;
    assign unused_memread = &{1'b0, idex_memread, xmem_memread};
`endif

    assign dwait_req = dmem_req && !dhit;

    // ------------------------------------------------------------------
    // State and bubble counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= S_RUN;
            bub_cnt <= 2'd0;
        end else if (halt_wb || (state == S_HALTED)) begin
            // Halt is terminal; only reset leaves it.
            state   <= S_HALTED;
        end else begin
            case (state)
                S_RUN: begin
                    if (dwait_req) begin
                        state <= S_DWAIT;
                    end else if (raw_hazard) begin
                        bub_cnt <= raw_load - 2'd1;
                        // A single-bubble hazard is fully served by this cycle.
                        state   <= (raw_load == 2'd1) ? S_RUN : S_BUBBLE;
                    end
                end
                S_BUBBLE: begin
                    if (dwait_req) begin
                        // Counter frozen while the whole pipe waits on memory.
                        state <= S_DWAIT;
                    end else begin
                        bub_cnt <= bub_cnt - 2'd1;
                        if (bub_cnt == 2'd1) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_DWAIT: begin
                    if (dhit) begin
                        state <= (bub_cnt != 2'd0) ? S_BUBBLE : S_RUN;
                    end
                end
                default: begin
                    state <= S_HALTED;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control outputs. Reset is folded in combinationally so the pipeline
    // latches see flush the moment nRST falls.
    // ------------------------------------------------------------------
    always_comb begin
        pc_en      = 1'b1;
        stall_ifid = 1'b0;
        stall_idex = 1'b0;
        stall_xmem = 1'b0;
        stall_wb   = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        flush_xmem = 1'b0;
        flush_wb   = 1'b0;

        if (!nRST) begin
            pc_en      = 1'b0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            flush_xmem = 1'b1;
            flush_wb   = 1'b1;
        end else if (halt_wb || (state == S_HALTED)) begin
            // Freeze everything, including the cycle HALT is seen in WB.
            pc_en      = 1'b0;
            stall_ifid = 1'b1;
            stall_idex = 1'b1;
            stall_xmem = 1'b1;
            stall_wb   = 1'b1;
        end else begin
            case (state)
                S_DWAIT: begin
                    // On the dhit cycle every latch advances (defaults).
                    if (!dhit) begin
                        pc_en      = 1'b0;
                        stall_ifid = 1'b1;
                        stall_idex = 1'b1;
                        stall_xmem = 1'b1;
                        flush_wb   = 1'b1;
                    end
                end
                S_RUN, S_BUBBLE: begin
                    if (dwait_req) begin
                        pc_en      = 1'b0;
                        stall_ifid = 1'b1;
                        stall_idex = 1'b1;
                        stall_xmem = 1'b1;
                        flush_wb   = 1'b1;
                    end else if ((state == S_BUBBLE) || raw_hazard) begin
                        // Hold the dependent instruction in ID, inject a bubble into EX.
                        pc_en      = 1'b0;
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end else if (!ihit) begin
                        // Fetch missed: keep PC, let the rest drain, no valid word into ID.
                        pc_en      = 1'b0;
                        flush_ifid = 1'b1;
                    end else if (take_branch || jump) begin
                        // Redirect: the sequentially fetched word is on the wrong path.
                        flush_ifid = 1'b1;
                    end
                end
                default: begin
                    pc_en = 1'b0;
                end
            endcase
        end
    end

    assign halted    = (state == S_HALTED);
    assign seq_state = state;

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, dmem_req, dhit, take_branch, jump, halt_wb;
    logic [4:0] id_rs, id_rt, idex_rd, xmem_rd;
    logic       idex_regwrite, idex_memread, xmem_regwrite, xmem_memread;
    logic       pc_en;
    logic       stall_ifid, stall_idex, stall_xmem, stall_wb;
    logic       flush_ifid, flush_idex, flush_xmem, flush_wb;
    logic       halted;
    logic [1:0] seq_state;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    pipeline_sequencer dut (
        .CLK(CLK), .nRST(nRST),
        .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .take_branch(take_branch), .jump(jump), .halt_wb(halt_wb),
        .id_rs(id_rs), .id_rt(id_rt), .idex_rd(idex_rd), .xmem_rd(xmem_rd),
        .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
        .xmem_regwrite(xmem_regwrite), .xmem_memread(xmem_memread),
        .pc_en(pc_en),
        .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_xmem(stall_xmem), .stall_wb(stall_wb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_xmem(flush_xmem), .flush_wb(flush_wb),
        .halted(halted), .seq_state(seq_state)
    );

    // Output vector: {pc_en, stall ifid/idex/xmem/wb, flush ifid/idex/xmem/wb, halted, seq_state}
    localparam logic [11:0] E_RST   = 12'b0_0000_1111_0_00;
    localparam logic [11:0] E_IDLE  = 12'b1_0000_0000_0_00;
    localparam logic [11:0] E_BUB0  = 12'b0_1000_0100_0_00;
    localparam logic [11:0] E_BUB2  = 12'b0_1000_0100_0_10;
    localparam logic [11:0] E_DW0   = 12'b0_1110_0001_0_00;
    localparam logic [11:0] E_DW1   = 12'b0_1110_0001_0_01;
    localparam logic [11:0] E_DW2   = 12'b0_1110_0001_0_10;
    localparam logic [11:0] E_DHIT  = 12'b1_0000_0000_0_01;
    localparam logic [11:0] E_MISS  = 12'b0_0000_1000_0_00;
    localparam logic [11:0] E_BR    = 12'b1_0000_1000_0_00;
    localparam logic [11:0] E_HALT1 = 12'b0_1111_0000_0_01;
    localparam logic [11:0] E_HLTD  = 12'b0_1111_0000_1_11;

    typedef struct {
        logic [11:0] v;
        string       n;
    } exp_t;

    exp_t sb[$];

    logic [11:0] act;
    assign act = {pc_en, stall_ifid, stall_idex, stall_xmem, stall_wb,
                  flush_ifid, flush_idex, flush_xmem, flush_wb, halted, seq_state};

    // Monitor: every cycle the DUT presents a control word; compare any
    // expectation queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s: got %b required %b", e.n, act, e.v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input logic [11:0] v, input string n);
        exp_t e;
        e.v = v;
        e.n = n;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dmem_req = 1'b0; dhit = 1'b0;
        take_branch = 1'b0; jump = 1'b0; halt_wb = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; idex_rd = 5'd0; xmem_rd = 5'd0;
        idex_regwrite = 1'b0; idex_memread = 1'b0;
        xmem_regwrite = 1'b0; xmem_memread = 1'b0;
    endtask

    initial begin
        nRST = 1'b0;
        idle_inputs();

        // Reset state
        tick(); expect_out(E_RST, "reset_outputs");
        tick(); nRST = 1'b1; expect_out(E_IDLE, "idle_after_reset");
        tick(); expect_out(E_IDLE, "idle_run");

`ifndef PIPELINE_SEQUENCER_FORWARD_EN
        // EX producer, no forwarding: two bubbles then RUN
        tick(); idex_rd = 5'd9; idex_regwrite = 1'b1; id_rt = 5'd9;
        expect_out(E_BUB0, "ex_raw_bubble1");
        tick(); idex_regwrite = 1'b0; xmem_rd = 5'd9; xmem_regwrite = 1'b1;
        expect_out(E_BUB2, "ex_raw_bubble2");
        tick(); idle_inputs(); expect_out(E_IDLE, "ex_raw_back_to_run");

        // MEM-only producer: single bubble
        tick(); xmem_rd = 5'd5; xmem_regwrite = 1'b1; id_rs = 5'd5;
        expect_out(E_BUB0, "mem_raw_bubble");
        tick(); idle_inputs(); expect_out(E_IDLE, "mem_raw_done");
`else
        // Load-use with forwarding: exactly one bubble
        tick(); idex_rd = 5'd8; idex_regwrite = 1'b1; idex_memread = 1'b1; id_rs = 5'd8;
        expect_out(E_BUB0, "loaduse_bubble");
        tick(); idle_inputs(); expect_out(E_IDLE, "loaduse_done");
        // ALU producer is forwarded: no stall
        tick(); idex_rd = 5'd8; idex_regwrite = 1'b1; id_rs = 5'd8;
        expect_out(E_IDLE, "alu_forwarded_no_stall");
        tick(); idle_inputs();
`endif
        // Register 0 never creates a dependency
        tick(); idex_rd = 5'd0; idex_regwrite = 1'b1; idex_memread = 1'b1;
        xmem_rd = 5'd0; xmem_regwrite = 1'b1; id_rs = 5'd0; id_rt = 5'd0;
        expect_out(E_IDLE, "r0_no_stall");
        tick(); idle_inputs(); idex_rd = 5'd8; idex_regwrite = 1'b1; idex_memread = 1'b1;
        id_rs = 5'd0; id_rt = 5'd3;
        expect_out(E_IDLE, "rs0_vs_rd8_no_stall");

        // Data wait: three miss cycles then hit
        tick(); idle_inputs(); dmem_req = 1'b1;
        expect_out(E_DW0, "dwait_c1");
        tick(); expect_out(E_DW1, "dwait_c2");
        tick(); expect_out(E_DW1, "dwait_c3");
        tick(); dhit = 1'b1; expect_out(E_DHIT, "dwait_hit_advance");
        tick(); idle_inputs(); expect_out(E_IDLE, "dwait_back_to_run");

`ifndef PIPELINE_SEQUENCER_FORWARD_EN
        // Data wait inside a bubble keeps the remaining bubble count
        tick(); idex_rd = 5'd12; idex_regwrite = 1'b1; id_rs = 5'd12;
        expect_out(E_BUB0, "bub_dw_detect");
        tick(); idle_inputs(); dmem_req = 1'b1;
        expect_out(E_DW2, "bub_dw_enter");
        tick(); dhit = 1'b1; expect_out(E_DHIT, "bub_dw_hit");
        tick(); idle_inputs(); expect_out(E_BUB2, "bub_dw_resume_bubble");
        tick(); expect_out(E_IDLE, "bub_dw_run");
`endif

        // Miss beats branch; branch with hit squashes the fetch
        tick(); ihit = 1'b0; take_branch = 1'b1; expect_out(E_MISS, "miss_beats_branch");
        tick(); ihit = 1'b1; expect_out(E_BR, "branch_squash");
        tick(); take_branch = 1'b0; jump = 1'b1; expect_out(E_BR, "jump_squash");
        tick(); idle_inputs(); expect_out(E_IDLE, "post_jump_idle");

        // RAW beats instruction miss
        tick(); ihit = 1'b0; idex_rd = 5'd7; idex_regwrite = 1'b1; idex_memread = 1'b1;
        id_rt = 5'd7;
        expect_out(E_BUB0, "raw_beats_miss");
        tick(); idle_inputs();
`ifndef PIPELINE_SEQUENCER_FORWARD_EN
        expect_out(E_BUB2, "raw_beats_miss_bubble2");
        tick();
`endif
        expect_out(E_IDLE, "raw_beats_miss_done");

`ifndef PIPELINE_SEQUENCER_FORWARD_EN
        // Reset in the middle of a bubble sequence
        tick(); idex_rd = 5'd9; idex_regwrite = 1'b1; id_rs = 5'd9;
        expect_out(E_BUB0, "rst_bub_detect");
        tick(); nRST = 1'b0; idle_inputs(); expect_out(E_RST, "rst_mid_bubble");
        tick(); nRST = 1'b1; expect_out(E_IDLE, "rst_release_run");
`endif

        // Halt arriving during data wait, then held regardless of inputs
        tick(); idle_inputs(); dmem_req = 1'b1; expect_out(E_DW0, "halt_dw_c1");
        tick(); expect_out(E_DW1, "halt_dw_c2");
        tick(); halt_wb = 1'b1; expect_out(E_HALT1, "halt_seen");
        for (int i = 0; i < 10; i++) begin
            tick();
            halt_wb  = 1'b0;
            ihit     = i[0];
            dmem_req = i[1];
            dhit     = i[2];
            take_branch = i[0];
            idex_rd = 5'd4; idex_regwrite = 1'b1; id_rs = (i[1] ? 5'd4 : 5'd0);
            expect_out(E_HLTD, $sformatf("halted_hold_%0d", i));
        end

        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
